// File: rtl/job_io_if.sv
// Byte-stream bundle between the host bridge and job_io_sr: RX job frame,
// job handoff to the core and TX result symbols.
interface job_io_if #(
  parameter int DW        = 8,
  parameter int JOB_BYTES = 80,
  parameter int RES_BYTES = 8
) ();
  logic [DW-1:0]           in_data;
  logic                    in_valid;
  logic                    in_sof;
  logic                    in_ready;
  logic [JOB_BYTES*DW-1:0] job_data;
  logic                    job_valid;
  logic                    job_ack;
  logic                    rx_abort;
  logic [RES_BYTES*DW-1:0] res_data;
  logic                    res_load;
  logic                    res_busy;
  logic [DW-1:0]           out_data;
  logic                    out_valid;
  logic                    out_ready;

  modport slave (
    input  in_data, in_valid, in_sof, job_ack, res_data, res_load, out_ready,
    output in_ready, job_data, job_valid, rx_abort, res_busy, out_data, out_valid
  );

  modport master (
    output in_data, in_valid, in_sof, job_ack, res_data, res_load, out_ready,
    input  in_ready, job_data, job_valid, rx_abort, res_busy, out_data, out_valid
  );
endinterface

// File: rtl/job_io_sr.sv
// Miner byte-stream front end: double-buffered framed job loader (RX) and
// flow-controlled result unloader (TX), fully independent halves.
module job_io_sr #(
  parameter int DW        = 8,
  parameter int JOB_BYTES = 80,
  parameter int RES_BYTES = 8
) (
  input  logic     clk,
  input  logic     rst_n,
  job_io_if.slave  bus
);
  localparam int JW = JOB_BYTES * DW;
  localparam int RW = RES_BYTES * DW;
  localparam int CW = $clog2(JOB_BYTES + 1);
  localparam int TW = $clog2(RES_BYTES + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    FULL = 2'd2
  } rx_state_e;

  rx_state_e     state_q, state_d;
  logic [JW-1:0] sh_q, sh_d;
  logic [JW-1:0] job_q, job_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          jv_q, jv_d;
  logic          abort_q, abort_d;
  logic [RW-1:0] tx_q, tx_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          busy_q, busy_d;

  logic          rx_xfer_s;
  logic [JW-1:0] sh_shift_s;
  logic [RW-1:0] tx_shift_s;

  assign rx_xfer_s = bus.in_valid & bus.in_ready;

  generate
    if (JOB_BYTES > 1) begin : g_sh_multi
      assign sh_shift_s = {sh_q[JW-DW-1:0], bus.in_data};
    end else begin : g_sh_single
      assign sh_shift_s = bus.in_data;
    end
    if (RES_BYTES > 1) begin : g_tx_multi
      assign tx_shift_s = {tx_q[RW-DW-1:0], {DW{1'b0}}};
    end else begin : g_tx_single
      assign tx_shift_s = {RW{1'b0}};
    end
  endgenerate

  // RX frame assembly and job handoff.
  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    job_d   = job_q;
    abort_d = 1'b0;
    if (jv_q && bus.job_ack) begin
      jv_d = 1'b0;
    end else begin
      jv_d = jv_q;
    end
    case (state_q)
      IDLE: begin
        if (rx_xfer_s && bus.in_sof) begin
          sh_d    = sh_shift_s;
          cnt_d   = CW'(1);
          state_d = (JOB_BYTES == 1) ? FULL : FILL;
        end else begin
          state_d = IDLE;
        end
      end
      FILL: begin
        if (rx_xfer_s) begin
          sh_d = sh_shift_s;
          if (bus.in_sof) begin
            cnt_d   = CW'(1);
            abort_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
            if (cnt_q + CW'(1) == CW'(JOB_BYTES)) begin
              state_d = FULL;
            end else begin
              state_d = FILL;
            end
          end
        end else begin
          state_d = FILL;
        end
      end
      FULL: begin
        // Hand over only once the core has released the previous job.
        if (!jv_q || bus.job_ack) begin
          job_d   = sh_q;
          jv_d    = 1'b1;
          cnt_d   = {CW{1'b0}};
          state_d = IDLE;
        end else begin
          state_d = FULL;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // TX result unloader; the shift fills with zeros so out_data idles at 0.
  always_comb begin
    tx_d   = tx_q;
    tcnt_d = tcnt_q;
    busy_d = busy_q;
    if (busy_q) begin
      if (bus.out_ready) begin
        tx_d   = tx_shift_s;
        tcnt_d = tcnt_q - TW'(1);
        if (tcnt_q == TW'(1)) begin
          busy_d = 1'b0;
        end else begin
          busy_d = 1'b1;
        end
      end else begin
        busy_d = 1'b1;
      end
    end else if (bus.res_load) begin
      tx_d   = bus.res_data;
      tcnt_d = TW'(RES_BYTES);
      busy_d = 1'b1;
    end else begin
      busy_d = 1'b0;
    end
  end

  // State registers for both halves.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sh_q    <= {JW{1'b0}};
      job_q   <= {JW{1'b0}};
      cnt_q   <= {CW{1'b0}};
      jv_q    <= 1'b0;
      abort_q <= 1'b0;
      tx_q    <= {RW{1'b0}};
      tcnt_q  <= {TW{1'b0}};
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      job_q   <= job_d;
      cnt_q   <= cnt_d;
      jv_q    <= jv_d;
      abort_q <= abort_d;
      tx_q    <= tx_d;
      tcnt_q  <= tcnt_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.in_ready  = (state_q != FULL);
  assign bus.job_data  = job_q;
  assign bus.job_valid = jv_q;
  assign bus.rx_abort  = abort_q;
  assign bus.res_busy  = busy_q;
  assign bus.out_valid = busy_q;
  assign bus.out_data  = tx_q[RW-1 -: DW];
endmodule

// File: tb/tb_job_io_sr.sv
// Directed bench for job_io_sr: queue-based frame/result model checked every
// cycle, plus literal expectations for each scenario.
module tb_job_io_sr;
  localparam int JB = 80;
  localparam int RB = 8;
  localparam int JW = JB * 8;

  logic clk = 1'b0;
  logic rst_n;
  logic chk_en = 1'b0;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  int   n_irdy_low = 0;
  int   n_abort = 0;
  int   n_jv_rise = 0;
  logic jv_prev = 1'b0;

  job_io_if bus ();
  job_io_sr dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [JW-1:0] act, input logic [JW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model: byte queues for the frame being assembled and the result being sent.
  logic [7:0]    frm[$];
  logic [7:0]    m_resq[$];
  logic [JW-1:0] m_pend = '0;
  logic [JW-1:0] m_job = '0;
  bit            m_full = 1'b0;
  bit            m_jv = 1'b0;
  bit            m_abort = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frm.delete();
      m_resq.delete();
      m_full = 1'b0;
      m_jv = 1'b0;
      m_abort = 1'b0;
      m_job = '0;
    end else begin
      bit xfer;
      xfer = bus.in_valid && !m_full;
      m_abort = 1'b0;
      if (m_full && (!m_jv || bus.job_ack)) begin
        m_job = m_pend;
        m_jv = 1'b1;
        m_full = 1'b0;
      end else if (bus.job_ack) begin
        m_jv = 1'b0;
      end
      if (xfer) begin
        if (bus.in_sof) begin
          if (frm.size() > 0) m_abort = 1'b1;
          frm.delete();
          frm.push_back(bus.in_data);
        end else if (frm.size() > 0) begin
          frm.push_back(bus.in_data);
        end
        if (frm.size() == JB) begin
          for (int i = 0; i < JB; i++) m_pend = {m_pend[JW-9:0], frm[i]};
          m_full = 1'b1;
          frm.delete();
        end
      end
      if (m_resq.size() > 0) begin
        if (bus.out_ready) void'(m_resq.pop_front());
      end else if (bus.res_load) begin
        for (int i = RB - 1; i >= 0; i--) m_resq.push_back(bus.res_data[i*8 +: 8]);
      end
    end
  end

  // Per-cycle comparison against the model, plus event counters.
  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      chk("in_ready", JW'(bus.in_ready), JW'(!m_full));
      chk("job_valid", JW'(bus.job_valid), JW'(m_jv));
      chk("job_data", bus.job_data, m_job);
      chk("rx_abort", JW'(bus.rx_abort), JW'(m_abort));
      chk("res_busy", JW'(bus.res_busy), JW'(m_resq.size() > 0));
      chk("out_valid", JW'(bus.out_valid), JW'(m_resq.size() > 0));
      chk("out_data", JW'(bus.out_data), (m_resq.size() > 0) ? JW'(m_resq[0]) : '0);
      if (!bus.in_ready) n_irdy_low++;
      if (bus.rx_abort) n_abort++;
      if (bus.job_valid && !jv_prev) n_jv_rise++;
    end
    jv_prev = bus.job_valid;
  end

  logic [7:0] got[$];
  always @(posedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) got.push_back(bus.out_data);
  end

  task automatic put(input logic [7:0] d, input logic s);
    int g;
    bus.in_data = d;
    bus.in_sof = s;
    bus.in_valid = 1'b1;
    g = 0;
    while (!bus.in_ready && g < 500) begin
      @(negedge clk);
      g++;
    end
    if (g >= 500) chk("put_timeout", JW'(bus.in_ready), JW'(1));
    @(negedge clk);
  endtask

  task automatic rx_idle();
    bus.in_valid = 1'b0;
    bus.in_sof = 1'b0;
  endtask

  task automatic wait_jv(input string nm);
    int g;
    g = 0;
    while (!bus.job_valid && g < 300) begin
      @(negedge clk);
      g++;
    end
    chk(nm, JW'(bus.job_valid), JW'(1));
  endtask

  task automatic ack();
    bus.job_ack = 1'b1;
    @(negedge clk);
    bus.job_ack = 1'b0;
  endtask

  logic [7:0] exp_sym[RB];
  int t0;
  int g;

  initial begin
    exp_sym = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF};
    rst_n = 1'b0;
    bus.in_data = 8'h00; bus.in_valid = 1'b0; bus.in_sof = 1'b0; bus.job_ack = 1'b0;
    bus.res_data = 64'h0; bus.res_load = 1'b0; bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", JW'(bus.in_ready), JW'(1));
    chk("rst_job_valid", JW'(bus.job_valid), JW'(0));
    chk("rst_job_data", bus.job_data, '0);
    chk("rst_out_valid", JW'(bus.out_valid), JW'(0));
    chk("rst_out_data", JW'(bus.out_data), JW'(0));
    rst_n = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);

    // 1: basic frame 0x00..0x4F
    n_irdy_low = 0;
    t0 = cyc;
    for (int i = 0; i < JB; i++) put(8'(i), i == 0);
    rx_idle();
    wait_jv("t1_jv");
    chk("t1_latency", JW'(cyc - t0), JW'(81));
    chk("t1_top", JW'(bus.job_data[639:632]), JW'(8'h00));
    chk("t1_low", JW'(bus.job_data[7:0]), JW'(8'h4F));
    chk("t1_irdy_low", JW'(n_irdy_low), JW'(1));

    // 2: double buffering, ack swaps in the pending job
    ack();
    for (int i = 0; i < JB; i++) put(8'(8'h20 + i), i == 0);
    rx_idle();
    wait_jv("t2_jv_a");
    for (int i = 0; i < JB; i++) put(8'(8'h80 + i), i == 0);
    rx_idle();
    repeat (3) @(negedge clk);
    chk("t2_stall", JW'(bus.in_ready), JW'(0));
    chk("t2_hold_a", JW'(bus.job_data[639:632]), JW'(8'h20));
    ack();
    chk("t2_jv_b", JW'(bus.job_valid), JW'(1));
    chk("t2_top_b", JW'(bus.job_data[639:632]), JW'(8'h80));
    chk("t2_low_b", JW'(bus.job_data[7:0]), JW'(8'hCF));
    ack();
    chk("t2_cleared", JW'(bus.job_valid), JW'(0));

    // 3: restart mid-frame
    n_abort = 0;
    n_jv_rise = 0;
    for (int i = 0; i < 40; i++) put(8'(8'h50 + i), i == 0);
    put(8'hAA, 1'b1);
    for (int i = 1; i < JB; i++) put(8'(8'h30 + i), 1'b0);
    rx_idle();
    wait_jv("t3_jv");
    repeat (2) @(negedge clk);
    chk("t3_abort_cnt", JW'(n_abort), JW'(1));
    chk("t3_top", JW'(bus.job_data[639:632]), JW'(8'hAA));
    chk("t3_low", JW'(bus.job_data[7:0]), JW'(8'h7F));
    chk("t3_jv_cnt", JW'(n_jv_rise), JW'(1));

    // 4+5: result unload with toggling out_ready and an ignored reload
    got.delete();
    bus.res_data = 64'h0123456789ABCDEF;
    bus.res_load = 1'b1;
    @(negedge clk);
    bus.res_load = 1'b0;
    g = 0;
    while (bus.res_busy && g < 100) begin
      bus.out_ready = ~bus.out_ready;
      bus.res_load = (g == 3 || g == 4);
      bus.res_data = (g == 3 || g == 4) ? 64'hFFEEDDCCBBAA9988 : 64'h0123456789ABCDEF;
      @(negedge clk);
      g++;
    end
    bus.out_ready = 1'b0;
    bus.res_load = 1'b0;
    chk("t4_busy_drop", JW'(bus.res_busy), JW'(0));
    chk("t4_count", JW'(got.size()), JW'(RB));
    for (int i = 0; i < RB; i++) begin
      if (i < got.size()) chk($sformatf("t4_sym%0d", i), JW'(got[i]), JW'(exp_sym[i]));
    end

    // 6: asynchronous reset mid-frame and mid-result
    for (int i = 0; i < 20; i++) put(8'(8'h60 + i), i == 0);
    bus.res_data = 64'h1122334455667788;
    bus.res_load = 1'b1;
    @(negedge clk);
    bus.res_load = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("t6_in_ready", JW'(bus.in_ready), JW'(1));
    chk("t6_job_valid", JW'(bus.job_valid), JW'(0));
    chk("t6_job_data", bus.job_data, '0);
    chk("t6_abort", JW'(bus.rx_abort), JW'(0));
    chk("t6_busy", JW'(bus.res_busy), JW'(0));
    chk("t6_out_valid", JW'(bus.out_valid), JW'(0));
    chk("t6_out_data", JW'(bus.out_data), JW'(0));
    rx_idle();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_jv_rise = 0;
    for (int i = 0; i < JB; i++) put(8'(8'h5A ^ i), i == 0);
    rx_idle();
    wait_jv("t6_jv");
    repeat (2) @(negedge clk);
    chk("t6_top", JW'(bus.job_data[639:632]), JW'(8'h5A));
    chk("t6_low", JW'(bus.job_data[7:0]), JW'(8'h15));
    chk("t6_jv_cnt", JW'(n_jv_rise), JW'(1));
    chk("t6_no_result", JW'(bus.out_valid), JW'(0));
    ack();

    // 7: bytes without SOF are dropped
    n_jv_rise = 0;
    for (int i = 0; i < JB + 5; i++) put(8'(8'hC0 + i), 1'b0);
    rx_idle();
    repeat (5) @(negedge clk);
    chk("t7_jv", JW'(bus.job_valid), JW'(0));
    chk("t7_jv_cnt", JW'(n_jv_rise), JW'(0));
    chk("t7_in_ready", JW'(bus.in_ready), JW'(1));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
